layer_sequencer: RTL

Layer-by-layer sequencer for the 64-lane reconfigurable CORDIC neuron array and its weight, bias and output banks. From a layer-count/neuron-count configuration it emits the strobes that stream weights and biases into the banks, step the MAC lanes through every input, apply bias and activation, and write back and shift the output bank. It replaces hand-driven control in the engine top level and keeps one strobe set per cycle.

---
 rtl/nn_ctrl_pkg.sv | 30 +++
 rtl/layer_sequencer_if.sv | 48 ++++
 rtl/layer_cfg_select.sv | 33 +++
 rtl/layer_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// =====================================================================
// nn_ctrl_pkg : shared types and defaults for the neuron-array control
// Rev 1.0
// =====================================================================
package nn_ctrl_pkg;

   localparam int NN_MAX_LAYERS = 5;
   localparam int NN_AF_LAT     = 4;
   localparam int NN_NL_PORTS   = 5;

   typedef logic [5:0] cnt_t;
   typedef cnt_t [NN_NL_PORTS-1:0]       nl_vec_t;
   typedef logic [NN_NL_PORTS-1:0][1:0]  af_vec_t;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LOAD_W = 4'd1,
      S_MAC    = 4'd2,
      S_SHIFT  = 4'd3,
      S_LOAD_B = 4'd4,
      S_BIAS   = 4'd5,
      S_ACT    = 4'd6,
      S_WRITE  = 4'd7,
      S_CLEAR  = 4'd8,
      S_DONE   = 4'd9
   } state_t;

endpackage
`default_nettype wire

// File: rtl/layer_sequencer_if.sv
`default_nettype none
// =====================================================================
// layer_sequencer_if : configuration, data-valid and strobe bundle
// Rev 1.0
// =====================================================================
interface layer_sequencer_if;
   import nn_ctrl_pkg::*;

   logic       start;
   cnt_t       no_layers;
   cnt_t       n_in;
   cnt_t       nl1, nl2, nl3, nl4, nl5;
   logic [1:0] afl1, afl2, afl3, afl4, afl5;
   logic       wt_valid;
   logic       bias_valid;

   logic       weight_en;
   logic       bias_en;
   logic       bias_sign;
   logic       mac_en;
   logic       compute_en;
   logic       af_en;
   logic [1:0] af_sel;
   logic       out_wr_en;
   logic       out_shft_en;
   logic       output_sig;
   cnt_t       n;
   cnt_t       i;
   logic       busy;
   logic       tot_complete;
   logic       cfg_err;

   modport master (
      output start, no_layers, n_in, nl1, nl2, nl3, nl4, nl5,
             afl1, afl2, afl3, afl4, afl5, wt_valid, bias_valid,
      input  weight_en, bias_en, bias_sign, mac_en, compute_en, af_en, af_sel,
             out_wr_en, out_shft_en, output_sig, n, i, busy, tot_complete, cfg_err
   );

   modport slave (
      input  start, no_layers, n_in, nl1, nl2, nl3, nl4, nl5,
             afl1, afl2, afl3, afl4, afl5, wt_valid, bias_valid,
      output weight_en, bias_en, bias_sign, mac_en, compute_en, af_en, af_sel,
             out_wr_en, out_shft_en, output_sig, n, i, busy, tot_complete, cfg_err
   );

endinterface
`default_nettype wire

// File: rtl/layer_cfg_select.sv
`default_nettype none
// =====================================================================
// layer_cfg_select : picks neuron count, fan-in and activation for a layer
// Rev 1.0
// =====================================================================
module layer_cfg_select
   import nn_ctrl_pkg::*;
(
   input  wire cnt_t       layer,
   input  wire cnt_t       n_in,
   input  wire nl_vec_t    nl,
   input  wire af_vec_t    afl,
   output cnt_t            neurons,
   output cnt_t            fan_in,
   output logic [1:0]      af_sel
);

   // Layer k>0 takes its fan-in from the neuron count of layer k-1.
   always_comb begin
      neurons = nl[0];
      fan_in  = n_in;
      af_sel  = afl[0];
      for (int k = 1; k < NN_NL_PORTS; k++) begin
         if (layer == cnt_t'(k)) begin
            neurons = nl[k];
            fan_in  = nl[k-1];
            af_sel  = afl[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// =====================================================================
// layer_sequencer : layer-by-layer strobe sequencer for the CORDIC array
// Rev 1.0
// =====================================================================
module layer_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int MAX_LAYERS = NN_MAX_LAYERS,
   parameter int AF_LAT     = NN_AF_LAT
) (
   input  wire logic         clk,
   input  wire logic         reset,
   layer_sequencer_if.slave  sif
);

   localparam cnt_t AF_LAST     = cnt_t'(AF_LAT - 1);
   localparam cnt_t LAYER_LIMIT = cnt_t'(MAX_LAYERS);

   state_t     state, state_nx;
   cnt_t       layer, layer_nx;
   cnt_t       idx, idx_nx;
   cnt_t       beat, beat_nx;
   logic       cfg_err_q, cfg_err_nx;
   cnt_t       cur_n, cur_f;
   logic [1:0] cur_af;
   logic       cfg_ok;
   logic       busy;
   nl_vec_t    nl_vec;
   af_vec_t    afl_vec;

   assign nl_vec  = {sif.nl5, sif.nl4, sif.nl3, sif.nl2, sif.nl1};
   assign afl_vec = {sif.afl5, sif.afl4, sif.afl3, sif.afl2, sif.afl1};

   layer_cfg_select u_cfg_select (
      .layer   (layer),
      .n_in    (sif.n_in),
      .nl      (nl_vec),
      .afl     (afl_vec),
      .neurons (cur_n),
      .fan_in  (cur_f),
      .af_sel  (cur_af)
   );

   // Only layers actually used must have a non-zero neuron count.
   always_comb begin
      cfg_ok = (sif.no_layers != '0) && (sif.no_layers <= LAYER_LIMIT) && (sif.n_in != '0);
      for (int k = 0; k < NN_NL_PORTS; k++) begin
         if ((cnt_t'(k) < sif.no_layers) && (nl_vec[k] == '0)) begin
            cfg_ok = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         layer     <= '0;
         idx       <= '0;
         beat      <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state     <= state_nx;
         layer     <= layer_nx;
         idx       <= idx_nx;
         beat      <= beat_nx;
         cfg_err_q <= cfg_err_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      layer_nx   = layer;
      idx_nx     = idx;
      beat_nx    = beat;
      cfg_err_nx = 1'b0;
      busy       = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            if (sif.start) begin
               if (!cfg_ok) begin
                  cfg_err_nx = 1'b1;
               end else begin
                  layer_nx = '0;
                  idx_nx   = '0;
                  beat_nx  = '0;
                  state_nx = S_LOAD_W;
               end
            end
         end
         S_LOAD_W: begin
            if (sif.wt_valid) begin
               if (beat == cur_n - 6'd1) begin
                  beat_nx  = '0;
                  state_nx = S_MAC;
               end else begin
                  beat_nx = beat + 6'd1;
               end
            end
         end
         S_MAC, S_SHIFT: begin
            // Hidden layers feed from output bank[0], which must shift after each MAC.
            if ((state == S_MAC) && (layer != '0)) begin
               state_nx = S_SHIFT;
            end else if (idx == cur_f - 6'd1) begin
               state_nx = S_LOAD_B;
            end else begin
               idx_nx   = idx + 6'd1;
               state_nx = S_LOAD_W;
            end
         end
         S_LOAD_B: begin
            if (sif.bias_valid) begin
               if (beat == cur_n - 6'd1) begin
                  beat_nx  = '0;
                  state_nx = S_BIAS;
               end else begin
                  beat_nx = beat + 6'd1;
               end
            end
         end
         S_BIAS: state_nx = S_ACT;
         S_ACT: begin
            if (beat == AF_LAST) begin
               beat_nx  = '0;
               state_nx = S_WRITE;
            end else begin
               beat_nx = beat + 6'd1;
            end
         end
         S_WRITE: state_nx = S_CLEAR;
         S_CLEAR: begin
            idx_nx = '0;
            if (layer == sif.no_layers - 6'd1) begin
               state_nx = S_DONE;
            end else begin
               layer_nx = layer + 6'd1;
               state_nx = S_LOAD_W;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      sif.weight_en    = (state == S_LOAD_W) && sif.wt_valid;
      sif.bias_en      = ((state == S_LOAD_B) && sif.bias_valid) || (state == S_BIAS);
      sif.bias_sign    = (state == S_BIAS);
      sif.mac_en       = (state == S_MAC);
      sif.compute_en   = state inside {S_LOAD_W, S_MAC, S_SHIFT, S_LOAD_B, S_BIAS, S_ACT, S_WRITE};
      sif.af_en        = (state == S_ACT);
      sif.af_sel       = busy ? cur_af : 2'b00;
      sif.out_wr_en    = (state == S_WRITE);
      sif.out_shft_en  = (state == S_SHIFT);
      sif.output_sig   = busy && (layer != '0);
      sif.n            = layer;
      sif.i            = idx;
      sif.busy         = busy;
      sif.tot_complete = (state == S_DONE);
      sif.cfg_err      = cfg_err_q;
   end

endmodule
`default_nettype wire
